// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the scoreboarded register file.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit vector: one pending-write flag per register with sweep/set/clear priority.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  input  logic             sweep_en,
  input  logic [AW-1:0]    sweep_idx,
  output logic [NREGS-1:0] busy
);

  // Set is applied after clear so a same-cycle issue to the written index keeps it busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (sweep_en) begin
      busy[sweep_idx] <= 1'b0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and a one-register-per-cycle clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            clear_req,
  output logic            clear_busy
);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_vec;

  logic idle, sweeping, wr_en, iss_en;
  logic [XLEN-1:0] stored1, stored2;

  assign idle     = (state_q == IDLE);
  assign sweeping = (state_q == SWEEP);
  assign wr_en    = idle && wb_en && (wb_rd != '0);
  assign iss_en   = idle && issue_valid && (issue_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = SWEEP;
      SWEEP:   if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = sweeping;
  end

  // The counter wraps back to 0 on the final sweep step, leaving it zeroed in IDLE.
  always_ff @(posedge clk) begin
    if (rst)                    cnt_q <= '0;
    else if (idle && clear_req) cnt_q <= AW'(1);
    else if (sweeping)          cnt_q <= cnt_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (sweeping) begin
      regs[cnt_q] <= '0;
    end else if (wr_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_en),
    .set_idx   (issue_rd),
    .clr_en    (wr_en),
    .clr_idx   (wb_rd),
    .sweep_en  (sweeping),
    .sweep_idx (cnt_q),
    .busy      (busy_vec)
  );

  assign stored1 = (rs1 == '0) ? '0 : regs[rs1];
  assign stored2 = (rs2 == '0) ? '0 : regs[rs2];

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = wr_en && (wb_rd == rs1);
  assign fwd2 = wr_en && (wb_rd == rs2);

  assign rd1_data = fwd1 ? wb_data : stored1;
  assign rd2_data = fwd2 ? wb_data : stored2;
  assign rs1_busy = (rs1 != '0) && !fwd1 && busy_vec[rs1];
  assign rs2_busy = (rs2 != '0) && !fwd2 && busy_vec[rs2];
`else
  assign rd1_data = stored1;
  assign rd2_data = stored2;
  assign rs1_busy = (rs1 != '0) && busy_vec[rs1];
  assign rs2_busy = (rs2 != '0) && busy_vec[rs2];
`endif

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of every register.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, 4..64.
REQ-003 SHALL derive AW = log2(NREGS) as the register index width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rs1, rs2  in  AW  read port indices.
REQ-008 rd1_data, rd2_data  out  XLEN  combinational read data.
REQ-009 rs1_busy, rs2_busy  out  1  register has a pending write (scoreboard).
REQ-010 issue_valid  in  1  an instruction that writes issue_rd is issued this cycle.
REQ-011 issue_rd  in  AW  destination of the issued instruction.
REQ-012 wb_en  in  1  writeback strobe.
REQ-013 wb_rd  in  AW  writeback index.
REQ-014 wb_data  in  XLEN  writeback data.
REQ-015 clear_req  in  1  one-cycle pulse starting a register sweep.
REQ-016 clear_busy  out  1  sweep in progress; requester stalls issue and writeback.

Function
REQ-017 Reads SHALL be asynchronous; register 0 SHALL always read 0 and never report busy.
REQ-018 wb_en with wb_rd != 0 SHALL write wb_data at the clock edge; the value is stored-visible the following cycle.
REQ-019 Scoreboard: issue_valid with issue_rd != 0 SHALL set busy[issue_rd]; wb_en with wb_rd != 0 SHALL clear busy[wb_rd].
REQ-020 Same-cycle issue and writeback to one index SHALL write the data and leave busy set (the younger issue wins).
REQ-021 Writes or issues to index 0 SHALL be silently dropped.
REQ-022 FSM states SHALL be IDLE and SWEEP; IDLE->SWEEP on clear_req; SWEEP->IDLE after the write to index NREGS-1.
REQ-023 In SWEEP, a counter SHALL start at 1 and zero one register per cycle, also clearing its busy bit; the sweep takes NREGS-1 cycles.
REQ-024 clear_busy SHALL be 1 exactly while in SWEEP; in SWEEP, wb_en, issue_valid and clear_req SHALL be ignored.
REQ-025 Reads during SWEEP SHALL return the current stored contents, with swept registers reading 0.

Reset
REQ-026 rst SHALL, in one cycle, zero all registers and busy bits, force IDLE, zero the sweep counter, and drive clear_busy=0.
REQ-027 rst asserted during SWEEP SHALL abort the sweep; rst SHALL take priority over every other input.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 Defined: when wb_en && wb_rd == rsX && wb_rd != 0 && state == IDLE, rdX_data SHALL equal wb_data and rsX_busy SHALL be 0 in the same cycle.
REQ-030 Undefined: reads SHALL return stored values only, and busy SHALL reflect registered state only.

Structure
REQ-031 Package regfile_pkg SHALL hold the default XLEN/NREGS constants and the FSM state enum (IDLE, SWEEP).
REQ-032 Sub-module regfile_scoreboard SHALL hold the busy-bit vector with its set/clear/priority logic; the data array, bypass logic and FSM stay in regfile_sb.

Verification
REQ-033 Write wb_rd=5, wb_data=0xDEADBEEF; rs1=5 next cycle -> rd1_data=0xDEADBEEF; write to x0 -> rd reads 0.
REQ-034 issue_rd=7 -> rs2_busy=1 next cycle; wb_rd=7 -> busy clears; same-cycle issue+wb of 7 -> data updated, busy stays 1.
REQ-035 Bypass build, wb_rd=3, wb_data=0x1234, rs1=3 in the same cycle -> rd1_data=0x1234 and rs1_busy=0; non-bypass build -> old value.
REQ-036 Fill all registers, pulse clear_req -> clear_busy=1 for 31 cycles (NREGS=32), all registers read 0, busy vector 0, wb during sweep dropped.
REQ-037 rst at cycle 10 of a sweep -> next cycle IDLE, clear_busy=0, all registers 0.
REQ-038 NREGS=16, XLEN=64 build -> sweep lasts 15 cycles, 64-bit write/read of 0xFFFF_0000_FFFF_0000 round-trips.
